// File: rtl/mem_arbiter_if.sv
// Bundle of both requester channels, the byte-wide memory port and the busy flag.
`timescale 1ns/1ps
interface mem_arbiter_if #(
  parameter int unsigned ADDR_W = 5
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [31:0]       if_rdata;
  logic              if_ack;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [31:0]       d_wdata;
  logic [31:0]       d_rdata;
  logic              d_ack;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic [7:0]        mem_rdata;

  logic              busy;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output if_rdata, if_ack, d_rdata, d_ack,
    output mem_en, mem_we, mem_addr, mem_wdata, busy
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  if_rdata, if_ack, d_rdata, d_ack,
    input  mem_en, mem_we, mem_addr, mem_wdata, busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port arbiter serialising 32-bit fetch/load/store words onto a byte-wide memory.
`timescale 1ns/1ps
module mem_arbiter #(
  parameter int unsigned ADDR_W     = 5,
  parameter bit          DATA_FIRST = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  mem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, XFER = 2'd1, ACK = 2'd2} state_t;

  state_t            state, nxt_state;
  logic [1:0]        cnt, nxt_cnt;
  logic              gnt_d, nxt_gnt_d;     // 1 = data port owns the transaction
  logic              prio_d, nxt_prio_d;   // 1 = data port wins the next tie
  logic              we_q, nxt_we;
  logic [ADDR_W-1:0] addr_q, nxt_addr;
  logic [31:0]       wdata_q, nxt_wdata;
  logic [31:0]       rword, nxt_rword;

  logic              nxt_mem_en, nxt_mem_we, nxt_if_ack, nxt_d_ack, nxt_busy;
  logic [ADDR_W-1:0] nxt_mem_addr;
  logic [7:0]        nxt_mem_wdata;
  logic [31:0]       nxt_if_rdata, nxt_d_rdata;

  function automatic logic [7:0] sel_byte(input logic [31:0] w, input logic [1:0] c);
    case (c)
      2'd0:    sel_byte = w[31:24];
      2'd1:    sel_byte = w[23:16];
      2'd2:    sel_byte = w[15:8];
      default: sel_byte = w[7:0];
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= 2'd0;
      gnt_d   <= 1'b0;
      prio_d  <= DATA_FIRST;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rword   <= '0;
    end else begin
      state   <= nxt_state;
      cnt     <= nxt_cnt;
      gnt_d   <= nxt_gnt_d;
      prio_d  <= nxt_prio_d;
      we_q    <= nxt_we;
      addr_q  <= nxt_addr;
      wdata_q <= nxt_wdata;
      rword   <= nxt_rword;
    end
  end

  // Arbitration, request latching, byte sequencing and read-lane capture.
  always_comb begin
    nxt_state  = state;
    nxt_cnt    = cnt;
    nxt_gnt_d  = gnt_d;
    nxt_prio_d = prio_d;
    nxt_we     = we_q;
    nxt_addr   = addr_q;
    nxt_wdata  = wdata_q;
    nxt_rword  = rword;
    case (state)
      IDLE: begin
        if (bus.if_req || bus.d_req) begin
          nxt_gnt_d  = bus.d_req && (!bus.if_req || prio_d);
          nxt_prio_d = !nxt_gnt_d;
          nxt_addr   = nxt_gnt_d ? bus.d_addr : bus.if_addr;
          nxt_we     = nxt_gnt_d && bus.d_we;
          nxt_wdata  = nxt_gnt_d ? bus.d_wdata : 32'h0;
          nxt_cnt    = 2'd0;
          nxt_state  = XFER;
        end
      end
      XFER: begin
        case (cnt)
          2'd0:    nxt_rword[31:24] = bus.mem_rdata;
          2'd1:    nxt_rword[23:16] = bus.mem_rdata;
          2'd2:    nxt_rword[15:8]  = bus.mem_rdata;
          default: nxt_rword[7:0]   = bus.mem_rdata;
        endcase
        nxt_cnt = cnt + 2'd1;
        if (cnt == 2'd3) nxt_state = ACK;
      end
      ACK:     nxt_state = IDLE;
      default: nxt_state = IDLE;
    endcase
  end

  // Next values of the registered outputs, derived from the upcoming state.
  always_comb begin
    nxt_mem_en    = (nxt_state == XFER);
    nxt_mem_we    = nxt_mem_en && nxt_we;
    nxt_mem_addr  = nxt_mem_en ? nxt_addr + ADDR_W'(nxt_cnt) : '0;
    nxt_mem_wdata = nxt_mem_we ? sel_byte(nxt_wdata, nxt_cnt) : 8'h00;
    nxt_if_ack    = (nxt_state == ACK) && !nxt_gnt_d;
    nxt_d_ack     = (nxt_state == ACK) && nxt_gnt_d;
    nxt_busy      = (nxt_state != IDLE);
    nxt_if_rdata  = bus.if_rdata;
    nxt_d_rdata   = bus.d_rdata;
    if (state == XFER && cnt == 2'd3 && !we_q) begin
      if (gnt_d) nxt_d_rdata  = nxt_rword;
      else       nxt_if_rdata = nxt_rword;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.mem_en    <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= 8'h00;
      bus.if_ack    <= 1'b0;
      bus.d_ack     <= 1'b0;
      bus.busy      <= 1'b0;
      bus.if_rdata  <= 32'h0;
      bus.d_rdata   <= 32'h0;
    end else begin
      bus.mem_en    <= nxt_mem_en;
      bus.mem_we    <= nxt_mem_we;
      bus.mem_addr  <= nxt_mem_addr;
      bus.mem_wdata <= nxt_mem_wdata;
      bus.if_ack    <= nxt_if_ack;
      bus.d_ack     <= nxt_d_ack;
      bus.busy      <= nxt_busy;
      bus.if_rdata  <= nxt_if_rdata;
      bus.d_rdata   <= nxt_d_rdata;
    end
  end

endmodule
